id_ex_reg: RTL and testbench
============================

ID_EX_REG -- requirements
Module: id_ex_reg

Interface
Parameters:
REQ-001 NB_DATA, 32, width of data paths (PC, operands, immediate).
REQ-002 NB_REG, 5, register-specifier width.
REQ-003 NB_OP, 6, opcode/funct width.
REQ-004 NB_CTRL, 15, packed control-bundle width; field layout defined in the shared package.
Ports:
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 i_rst  in  1  synchronous, active-high reset.
REQ-007 i_valid  in  1  ID-stage slot holds a real instruction.
REQ-008 i_ctrl  in  NB_CTRL  packed decoder bundle: jump, aluSrc[1:0], aluOp[1:0], branch, regDst, mem2Reg, regWrite, memRead, memWrite, width[1:0], sign_flag, immediate.
REQ-009 i_pc4, i_rs_data, i_rt_data, i_imm_ext  in  NB_DATA each  ID-stage data.
REQ-010 i_rs, i_rt, i_rd  in  NB_REG each  register specifiers.
REQ-011 i_funct  in  NB_OP  function field.
REQ-012 i_stall  in  1  downstream hold request.
REQ-013 i_flush  in  1  squash request (taken branch/jump).
REQ-014 o_valid, o_ctrl, o_pc4, o_rs_data, o_rt_data, o_imm_ext, o_rs, o_rt, o_rd, o_funct  out  widths as inputs  registered EX-stage copies.
REQ-015 o_wr_reg  out  NB_REG  registered destination: i_rd when regDst=1, else i_rt.
REQ-016 o_load_use  out  1  combinational load-use hazard indication.
REQ-017 o_stall_up  out  1  combinational hold request to IF/ID and PC.
REQ-018 o_bubble_cnt  out  32  load-use bubble counter (see Configuration).

Function
REQ-019 o_load_use SHALL equal o_valid & o_ctrl.memRead & (o_wr_reg != 0) & (o_wr_reg == i_rs | o_wr_reg == i_rt) & i_valid.
REQ-020 o_stall_up SHALL equal i_stall | (o_load_use & ~i_flush).
REQ-021 Per-edge priority SHALL be: i_rst > i_flush > i_stall > load-use bubble > load.
REQ-022 Flush: o_valid<=0, o_ctrl<=0, all data/specifier outputs <=0, o_wr_reg<=0.
REQ-023 Stall (no flush): every register holds its value.
REQ-024 Bubble (o_load_use, no flush/stall): o_valid<=0, o_ctrl<=0, data outputs <=0; the ID instruction stays upstream for replay.
REQ-025 Load: all outputs capture inputs; o_ctrl<=i_ctrl only if i_valid, else 0.
REQ-026 Latency exactly one cycle from input to output on a load edge; no combinational input-to-registered-output path.
REQ-027 A bubble SHALL clear the hazard on the next cycle (o_valid=0), so the replayed instruction loads on the following edge; max consecutive bubbles per load = 1.
REQ-028 Flush and load-use in the same cycle: flush wins; no bubble counted.

Reset
REQ-029 While i_rst=1 at a rising edge, every registered output and o_bubble_cnt SHALL become 0; i_stall and i_flush are ignored.
REQ-030 A reset asserted mid-stall SHALL clear state; after release the block loads normally on the first edge.

Configuration
REQ-031 Macro IDEX_PERF_CNT_EN defined: o_bubble_cnt increments by 1 on each bubble edge (REQ-024), saturating at 0xFFFF_FFFF.
REQ-032 Macro undefined: o_bubble_cnt is tied to 0 and no counter logic is synthesized; all other behaviour identical.

Structure
REQ-033 Package mips_pkg SHALL hold NB_CTRL, the control-field bit positions/widths, and the opcode constants (R_TYPE, LW, SW, BEQ, ADDI, ORI, J, LUI, LB) shared with control_unit.
REQ-034 The block SHALL be a single module; the hazard compare is inline, no sub-module.

Verification
REQ-035 Reset: i_rst=1 for 2 cycles with nonzero inputs -> all outputs 0, o_bubble_cnt=0.
REQ-036 Load: i_valid=1, i_ctrl=R_TYPE add bundle, i_rs=1, i_rt=2, i_rd=3 -> next cycle o_valid=1, o_wr_reg=3, o_ctrl equals input.
REQ-037 Load-use: LW with rt=5 in EX, ID instruction i_rs=5 -> o_load_use=1, o_stall_up=1; next cycle o_valid=0, o_ctrl=0, o_bubble_cnt=1 (macro on); following cycle replay loads.
REQ-038 No false hazard: LW to $0 with i_rs=0 -> o_load_use=0; LW rt=5 with i_rs=6, i_rt=7 -> o_load_use=0.
REQ-039 Stall vs flush: i_stall=1 for 3 cycles -> outputs unchanged; i_stall=1 and i_flush=1 together -> outputs cleared to 0.
REQ-040 Flush during load-use: o_load_use=1 and i_flush=1 -> o_stall_up=i_stall, outputs cleared, o_bubble_cnt unchanged.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: control-bundle width and field positions, plus opcodes.
// Used by control_unit (producer) and id_ex_reg (consumer) so the bundle layout stays in one place.
package mips_pkg;

    localparam int NB_CTRL = 15;

    // Control bundle, MSB first: jump, aluSrc[1:0], aluOp[1:0], branch, regDst,
    // mem2Reg, regWrite, memRead, memWrite, width[1:0], sign_flag, immediate.
    localparam int CTRL_JUMP      = 14;
    localparam int CTRL_ALU_SRC   = 12;
    localparam int NB_ALU_SRC     = 2;
    localparam int CTRL_ALU_OP    = 10;
    localparam int NB_ALU_OP      = 2;
    localparam int CTRL_BRANCH    = 9;
    localparam int CTRL_REG_DST   = 8;
    localparam int CTRL_MEM2REG   = 7;
    localparam int CTRL_REG_WRITE = 6;
    localparam int CTRL_MEM_READ  = 5;
    localparam int CTRL_MEM_WRITE = 4;
    localparam int CTRL_WIDTH     = 2;
    localparam int NB_WIDTH       = 2;
    localparam int CTRL_SIGN      = 1;
    localparam int CTRL_IMM       = 0;

    localparam logic [5:0] R_TYPE = 6'b000000;
    localparam logic [5:0] LW     = 6'b100011;
    localparam logic [5:0] SW     = 6'b101011;
    localparam logic [5:0] BEQ    = 6'b000100;
    localparam logic [5:0] ADDI   = 6'b001000;
    localparam logic [5:0] ORI    = 6'b001101;
    localparam logic [5:0] J      = 6'b000010;
    localparam logic [5:0] LUI    = 6'b001111;
    localparam logic [5:0] LB     = 6'b100000;

endpackage

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with inline load-use detection; 1-cycle latency, stall holds all state.
// Flush and load-use bubbles clear the slot; IDEX_PERF_CNT_EN adds a saturating bubble counter.
module id_ex_reg
    import mips_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5,
    parameter int NB_OP   = 6,
    parameter int NB_CTRL = mips_pkg::NB_CTRL
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_valid,
    input  logic [NB_CTRL-1:0] i_ctrl,
    input  logic [NB_DATA-1:0] i_pc4,
    input  logic [NB_DATA-1:0] i_rs_data,
    input  logic [NB_DATA-1:0] i_rt_data,
    input  logic [NB_DATA-1:0] i_imm_ext,
    input  logic [NB_REG-1:0]  i_rs,
    input  logic [NB_REG-1:0]  i_rt,
    input  logic [NB_REG-1:0]  i_rd,
    input  logic [NB_OP-1:0]   i_funct,
    input  logic               i_stall,
    input  logic               i_flush,
    output logic               o_valid,
    output logic [NB_CTRL-1:0] o_ctrl,
    output logic [NB_DATA-1:0] o_pc4,
    output logic [NB_DATA-1:0] o_rs_data,
    output logic [NB_DATA-1:0] o_rt_data,
    output logic [NB_DATA-1:0] o_imm_ext,
    output logic [NB_REG-1:0]  o_rs,
    output logic [NB_REG-1:0]  o_rt,
    output logic [NB_REG-1:0]  o_rd,
    output logic [NB_OP-1:0]   o_funct,
    output logic [NB_REG-1:0]  o_wr_reg,
    output logic               o_load_use,
    output logic               o_stall_up,
    output logic [31:0]        o_bubble_cnt
);

    logic bubble;

    assign o_load_use = o_valid & o_ctrl[CTRL_MEM_READ] & (o_wr_reg != '0)
                      & ((o_wr_reg == i_rs) | (o_wr_reg == i_rt)) & i_valid;
    assign o_stall_up = i_stall | (o_load_use & ~i_flush);
    assign bubble     = o_load_use & ~i_flush & ~i_stall;

    always_ff @(posedge clk) begin
        if (i_rst || i_flush || bubble) begin
            // A bubble leaves the ID instruction upstream, so clearing the slot loses nothing.
            o_valid   <= 1'b0;
            o_ctrl    <= '0;
            o_pc4     <= '0;
            o_rs_data <= '0;
            o_rt_data <= '0;
            o_imm_ext <= '0;
            o_rs      <= '0;
            o_rt      <= '0;
            o_rd      <= '0;
            o_funct   <= '0;
            o_wr_reg  <= '0;
        end else if (!i_stall) begin
            o_valid   <= i_valid;
            o_ctrl    <= i_valid ? i_ctrl : '0;
            o_pc4     <= i_pc4;
            o_rs_data <= i_rs_data;
            o_rt_data <= i_rt_data;
            o_imm_ext <= i_imm_ext;
            o_rs      <= i_rs;
            o_rt      <= i_rt;
            o_rd      <= i_rd;
            o_funct   <= i_funct;
            o_wr_reg  <= i_ctrl[CTRL_REG_DST] ? i_rd : i_rt;
        end
    end

`ifdef IDEX_PERF_CNT_EN
    logic [31:0] bubble_cnt;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            bubble_cnt <= '0;
        end else if (bubble && (bubble_cnt != 32'hFFFF_FFFF)) begin
            bubble_cnt <= bubble_cnt + 32'd1;
        end
    end

    assign o_bubble_cnt = bubble_cnt;
`else
    assign o_bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed table-driven bench for id_ex_reg plus hand sequences for reset and reset-during-stall.
module tb_id_ex_reg;
    import mips_pkg::*;

`ifdef IDEX_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // R-type add: aluOp=10, regDst, regWrite.  LW: aluSrc=01, mem2Reg, regWrite, memRead, width=11, immediate.
    localparam logic [14:0] C_RT = 15'h0940;
    localparam logic [14:0] C_LW = 15'h10ED;

    logic        clk = 1'b0;
    logic        rst, valid, stall, flush;
    logic [14:0] ctrl;
    logic [31:0] pc4, rs_data, rt_data, imm_ext;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic        q_valid, load_use, stall_up;
    logic [14:0] q_ctrl;
    logic [31:0] q_pc4, q_rs_data, q_rt_data, q_imm_ext, bubble_cnt;
    logic [4:0]  q_rs, q_rt, q_rd, wr_reg;
    logic [5:0]  q_funct;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    id_ex_reg dut (
        .clk(clk), .i_rst(rst), .i_valid(valid), .i_ctrl(ctrl),
        .i_pc4(pc4), .i_rs_data(rs_data), .i_rt_data(rt_data), .i_imm_ext(imm_ext),
        .i_rs(rs), .i_rt(rt), .i_rd(rd), .i_funct(funct),
        .i_stall(stall), .i_flush(flush),
        .o_valid(q_valid), .o_ctrl(q_ctrl), .o_pc4(q_pc4), .o_rs_data(q_rs_data),
        .o_rt_data(q_rt_data), .o_imm_ext(q_imm_ext), .o_rs(q_rs), .o_rt(q_rt),
        .o_rd(q_rd), .o_funct(q_funct), .o_wr_reg(wr_reg), .o_load_use(load_use),
        .o_stall_up(stall_up), .o_bubble_cnt(bubble_cnt)
    );

    typedef struct {
        logic        v;
        logic [14:0] ctrl;
        logic [4:0]  rs, rt, rd;
        logic [31:0] d;
        logic        stall, flush;
        logic        e_lu, e_su, e_v;
        logic [14:0] e_ctrl;
        logic        e_clr, e_spec;
        logic [4:0]  e_rs, e_rt, e_rd, e_wr;
        logic [31:0] e_d;
        int          e_bc;
    } vec_t;

    vec_t tbl[20];

    function automatic vec_t mk(input logic v, input logic [14:0] c, input logic [4:0] a, b, r,
                                input logic [31:0] d, input logic s, f,
                                input logic elu, esu, ev, input logic [14:0] ec,
                                input logic eclr, espec, input logic [4:0] ers, ert, erd, ewr,
                                input logic [31:0] ed, input int ebc);
        vec_t t;
        t.v = v; t.ctrl = c; t.rs = a; t.rt = b; t.rd = r; t.d = d; t.stall = s; t.flush = f;
        t.e_lu = elu; t.e_su = esu; t.e_v = ev; t.e_ctrl = ec; t.e_clr = eclr; t.e_spec = espec;
        t.e_rs = ers; t.e_rt = ert; t.e_rd = erd; t.e_wr = ewr; t.e_d = ed; t.e_bc = ebc;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [14:0] c, input logic [4:0] a, b, r,
                         input logic [31:0] d, input logic s, f);
        valid = v; ctrl = c; rs = a; rt = b; rd = r; stall = s; flush = f;
        pc4 = d; rs_data = d + 32'd1; rt_data = d + 32'd2; imm_ext = d + 32'd3; funct = d[9:4];
    endtask

    task automatic check_data(input string tag, input logic clr, input logic [31:0] d);
        check({tag, ".pc4"},     q_pc4,     clr ? 32'd0 : d);
        check({tag, ".rs_data"}, q_rs_data, clr ? 32'd0 : d + 32'd1);
        check({tag, ".rt_data"}, q_rt_data, clr ? 32'd0 : d + 32'd2);
        check({tag, ".imm_ext"}, q_imm_ext, clr ? 32'd0 : d + 32'd3);
        check({tag, ".funct"},   32'(q_funct), clr ? 32'd0 : 32'(d[9:4]));
    endtask

    initial begin
        //      v  ctrl  rs rt rd d       st fl  lu su ev e_ctrl clr spc ers ert erd ewr e_d     bc
        tbl[0]  = mk(1, C_RT, 1, 2, 3, 'h100, 0, 0,  0, 0, 1, C_RT, 0, 1, 1, 2, 3, 3, 'h100, 0);
        tbl[1]  = mk(1, C_LW, 1, 5, 9, 'h200, 0, 0,  0, 0, 1, C_LW, 0, 1, 1, 5, 9, 5, 'h200, 0);
        tbl[2]  = mk(1, C_RT, 5, 4, 6, 'h300, 0, 0,  1, 1, 0, 0,    1, 0, 0, 0, 0, 0, 0,     1);
        tbl[3]  = mk(1, C_RT, 5, 4, 6, 'h300, 0, 0,  0, 0, 1, C_RT, 0, 1, 5, 4, 6, 6, 'h300, 1);
        tbl[4]  = mk(1, C_LW, 7, 8, 9, 'h400, 1, 0,  0, 1, 1, C_RT, 0, 1, 5, 4, 6, 6, 'h300, 1);
        tbl[5]  = tbl[4];
        tbl[6]  = tbl[4];
        tbl[7]  = mk(1, C_LW, 3, 0, 0, 'h500, 0, 0,  0, 0, 1, C_LW, 0, 1, 3, 0, 0, 0, 'h500, 1);
        tbl[8]  = mk(1, C_LW, 0, 5, 1, 'h600, 0, 0,  0, 0, 1, C_LW, 0, 1, 0, 5, 1, 5, 'h600, 1);
        tbl[9]  = mk(1, C_RT, 6, 7, 8, 'h700, 0, 0,  0, 0, 1, C_RT, 0, 1, 6, 7, 8, 8, 'h700, 1);
        tbl[10] = mk(1, C_LW, 1, 5, 2, 'h800, 0, 0,  0, 0, 1, C_LW, 0, 1, 1, 5, 2, 5, 'h800, 1);
        tbl[11] = mk(1, C_RT, 3, 5, 4, 'h900, 0, 1,  1, 0, 0, 0,    1, 1, 0, 0, 0, 0, 0,     1);
        tbl[12] = mk(1, C_LW, 1, 5, 2, 'hA00, 0, 0,  0, 0, 1, C_LW, 0, 1, 1, 5, 2, 5, 'hA00, 1);
        tbl[13] = mk(1, C_RT, 3, 5, 4, 'h900, 1, 1,  1, 1, 0, 0,    1, 1, 0, 0, 0, 0, 0,     1);
        tbl[14] = mk(1, C_LW, 1, 5, 2, 'hB00, 0, 0,  0, 0, 1, C_LW, 0, 1, 1, 5, 2, 5, 'hB00, 1);
        tbl[15] = mk(0, C_RT, 5, 5, 4, 'hC00, 0, 0,  0, 0, 0, 0,    0, 1, 5, 5, 4, 4, 'hC00, 1);
        tbl[16] = mk(1, C_LW, 1, 5, 2, 'hD00, 0, 0,  0, 0, 1, C_LW, 0, 1, 1, 5, 2, 5, 'hD00, 1);
        tbl[17] = mk(1, C_RT, 5, 4, 6, 'hE00, 1, 0,  1, 1, 1, C_LW, 0, 1, 1, 5, 2, 5, 'hD00, 1);
        tbl[18] = mk(1, C_RT, 5, 4, 6, 'hE00, 0, 0,  1, 1, 0, 0,    1, 0, 0, 0, 0, 0, 0,     2);
        tbl[19] = mk(1, C_RT, 5, 4, 6, 'hE00, 0, 0,  0, 0, 1, C_RT, 0, 1, 5, 4, 6, 6, 'hE00, 2);

        // Reset for two edges with nonzero inputs and stall/flush asserted.
        rst = 1'b1;
        drive(1, C_LW, 5, 5, 5, 'h1234_5670, 1, 1);
        repeat (2) @(posedge clk);
        #1;
        check("rst.valid", 32'(q_valid), 32'd0);
        check("rst.ctrl", 32'(q_ctrl), 32'd0);
        check_data("rst", 1'b1, 32'd0);
        check("rst.rs", 32'(q_rs), 32'd0);
        check("rst.rt", 32'(q_rt), 32'd0);
        check("rst.rd", 32'(q_rd), 32'd0);
        check("rst.wr_reg", 32'(wr_reg), 32'd0);
        check("rst.load_use", 32'(load_use), 32'd0);
        check("rst.bubble_cnt", bubble_cnt, 32'd0);

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            @(negedge clk);
            drive(tbl[i].v, tbl[i].ctrl, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].d,
                  tbl[i].stall, tbl[i].flush);
            #1;
            check({tag, ".load_use"}, 32'(load_use), 32'(tbl[i].e_lu));
            check({tag, ".stall_up"}, 32'(stall_up), 32'(tbl[i].e_su));
            @(posedge clk);
            #1;
            check({tag, ".valid"}, 32'(q_valid), 32'(tbl[i].e_v));
            check({tag, ".ctrl"}, 32'(q_ctrl), 32'(tbl[i].e_ctrl));
            check_data(tag, tbl[i].e_clr, tbl[i].e_d);
            if (tbl[i].e_spec) begin
                check({tag, ".rs"}, 32'(q_rs), 32'(tbl[i].e_rs));
                check({tag, ".rt"}, 32'(q_rt), 32'(tbl[i].e_rt));
                check({tag, ".rd"}, 32'(q_rd), 32'(tbl[i].e_rd));
                check({tag, ".wr_reg"}, 32'(wr_reg), 32'(tbl[i].e_wr));
            end
            check({tag, ".bubble_cnt"}, bubble_cnt, PERF ? 32'(tbl[i].e_bc) : 32'd0);
        end

        // Reset while stalled clears state; first edge after release loads normally.
        @(negedge clk);
        drive(1, C_LW, 7, 8, 9, 'h4000, 1, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_stall.valid", 32'(q_valid), 32'd0);
        check("rst_stall.ctrl", 32'(q_ctrl), 32'd0);
        check("rst_stall.pc4", q_pc4, 32'd0);
        check("rst_stall.wr_reg", 32'(wr_reg), 32'd0);
        check("rst_stall.bubble_cnt", bubble_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1, C_LW, 1, 5, 2, 'hF00, 0, 0);
        @(posedge clk);
        #1;
        check("post_rst.valid", 32'(q_valid), 32'd1);
        check("post_rst.ctrl", 32'(q_ctrl), 32'(C_LW));
        check("post_rst.wr_reg", 32'(wr_reg), 32'd5);
        check("post_rst.pc4", q_pc4, 32'hF00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
